// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with EX/MEM pipeline register and an iterative
// shift-add multiplier that stalls upstream while it runs.
`default_nettype none

module ex_stage_mc #(
    parameter int XLEN     = 32,
    parameter int RADDR    = 5,
    parameter int BR_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic             flush_i,
    input  logic             mem_stall_i,
    input  logic [1:0]       wb_ctl_i,
    input  logic [2:0]       m_ctl_i,
    input  logic             regdst_i,
    input  logic             alusrc_i,
    input  logic [1:0]       aluop_i,
    input  logic [XLEN-1:0]  npc_i,
    input  logic [XLEN-1:0]  rdata1_i,
    input  logic [XLEN-1:0]  rdata2_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [RADDR-1:0] rt_i,
    input  logic [RADDR-1:0] rd_i,
    input  logic [5:0]       funct_i,
    output logic             ex_busy_o,
    output logic             out_valid_o,
    output logic [1:0]       wb_ctlout_o,
    output logic             branch_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic [XLEN-1:0]  ex_mem_npc_o,
    output logic             zero_o,
    output logic [XLEN-1:0]  alu_result_o,
    output logic [XLEN-1:0]  rdata2out_o,
    output logic [RADDR-1:0] wreg_o
);

    localparam int             CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOR = 3'd4,
        OP_SLT = 3'd5,
        OP_MUL = 3'd6
    } op_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;

    logic             valid_q;
    logic [1:0]       wb_q;
    logic [2:0]       m_q;
    logic [XLEN-1:0]  npc_q;
    logic             zero_q;
    logic [XLEN-1:0]  res_q;
    logic [XLEN-1:0]  rd2_q;
    logic [RADDR-1:0] wreg_q;

    op_e             op;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] acc_step;
    logic [XLEN-1:0] load_res;
    logic            load_ex;
    logic            bubble;
    logic            busy;

    assign opb = alusrc_i ? imm_i : rdata2_i;

    always_comb begin
        op = OP_ADD;
        case (aluop_i)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_OR;
            default: begin
                case (funct_i)
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b011000: op = OP_MUL;
                    default:   op = OP_ADD;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = rdata1_i + opb;
        case (op)
            OP_SUB:  alu_res = rdata1_i - opb;
            OP_AND:  alu_res = rdata1_i & opb;
            OP_OR:   alu_res = rdata1_i | opb;
            OP_NOR:  alu_res = ~(rdata1_i | opb);
            OP_SLT:  alu_res = XLEN'($signed(rdata1_i) < $signed(opb));
            default: alu_res = rdata1_i + opb;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        load_ex  = 1'b0;
        load_res = alu_res;
        bubble   = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = in_valid_i && ((op == OP_MUL) || mem_stall_i);
                if (in_valid_i && !mem_stall_i) begin
                    if (op == OP_MUL) begin
                        mcand_d  = rdata1_i;
                        mplier_d = opb;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                        bubble   = 1'b1;
                    end else begin
                        load_ex = 1'b1;
                    end
                end else if (!in_valid_i && !mem_stall_i) begin
                    bubble = 1'b1;
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                busy     = !((cnt_q == CNT_LAST) && !mem_stall_i);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!mem_stall_i) begin
                        load_ex  = 1'b1;
                        load_res = acc_step;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy = 1'b1;
                if (!mem_stall_i) begin
                    load_ex  = 1'b1;
                    load_res = acc_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A kill overrides everything, including a pending stall.
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            load_ex = 1'b0;
            bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
            m_q     <= '0;
            npc_q   <= '0;
            zero_q  <= 1'b0;
            res_q   <= '0;
            rd2_q   <= '0;
            wreg_q  <= '0;
        end else if (load_ex) begin
            valid_q <= 1'b1;
            wb_q    <= wb_ctl_i;
            m_q     <= m_ctl_i;
            npc_q   <= npc_i + (imm_i << BR_SHIFT);
            zero_q  <= (load_res == '0);
            res_q   <= load_res;
            rd2_q   <= rdata2_i;
            wreg_q  <= regdst_i ? rd_i : rt_i;
        end else if (bubble) begin
            valid_q <= 1'b0;
        end
    end

    assign ex_busy_o    = busy;
    assign out_valid_o  = valid_q;
    assign wb_ctlout_o  = wb_q;
    assign branch_o     = m_q[2];
    assign memread_o    = m_q[1];
    assign memwrite_o   = m_q[0];
    assign ex_mem_npc_o = npc_q;
    assign zero_o       = zero_q;
    assign alu_result_o = res_q;
    assign rdata2out_o  = rd2_q;
    assign wreg_o       = wreg_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: random and directed checks of ex_stage_mc against a
// transaction-level model that uses plain arithmetic for every result.
`default_nettype none

module tb_ex_stage_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i, flush_i, mem_stall_i;
    logic [1:0]  wb_ctl_i;
    logic [2:0]  m_ctl_i;
    logic        regdst_i, alusrc_i;
    logic [1:0]  aluop_i;
    logic [31:0] npc_i, rdata1_i, rdata2_i, imm_i;
    logic [4:0]  rt_i, rd_i;
    logic [5:0]  funct_i;
    logic        ex_busy_o, out_valid_o, branch_o, memread_o, memwrite_o, zero_o;
    logic [1:0]  wb_ctlout_o;
    logic [31:0] ex_mem_npc_o, alu_result_o, rdata2out_o;
    logic [4:0]  wreg_o;

    ex_stage_mc #(.XLEN(32), .RADDR(5), .BR_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .flush_i(flush_i),
        .mem_stall_i(mem_stall_i), .wb_ctl_i(wb_ctl_i), .m_ctl_i(m_ctl_i),
        .regdst_i(regdst_i), .alusrc_i(alusrc_i), .aluop_i(aluop_i),
        .npc_i(npc_i), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .imm_i(imm_i),
        .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i), .ex_busy_o(ex_busy_o),
        .out_valid_o(out_valid_o), .wb_ctlout_o(wb_ctlout_o), .branch_o(branch_o),
        .memread_o(memread_o), .memwrite_o(memwrite_o), .ex_mem_npc_o(ex_mem_npc_o),
        .zero_o(zero_o), .alu_result_o(alu_result_o), .rdata2out_o(rdata2out_o),
        .wreg_o(wreg_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 multiplying, 2 product waiting on MEM.
    int          m_mode;
    int          m_left;
    logic [31:0] m_prod;
    logic        m_loaded, m_flushed;
    logic        e_valid, e_zero;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [31:0] e_npc, e_res, e_rd2;
    logic [4:0]  e_wreg;

    function automatic void ref_op(output logic [31:0] r, output logic mul);
        logic [31:0] a, b;
        a   = rdata1_i;
        b   = alusrc_i ? imm_i : rdata2_i;
        mul = 1'b0;
        case (aluop_i)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b11: r = a | b;
            default: case (funct_i)
                6'h22:   r = a - b;
                6'h24:   r = a & b;
                6'h25:   r = a | b;
                6'h27:   r = ~(a | b);
                6'h2a:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h18:   begin r = a * b; mul = 1'b1; end
                default: r = a + b;
            endcase
        endcase
    endfunction

    function automatic logic model_busy();
        logic [31:0] r;
        logic        mul;
        ref_op(r, mul);
        if (m_mode == 0) return in_valid_i && (mul || mem_stall_i);
        if (m_mode == 1) return !(m_left == 1 && !mem_stall_i);
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_prod = 0;
        e_valid = 0; e_zero = 0; e_wb = 0; e_m = 0;
        e_npc = 0; e_res = 0; e_rd2 = 0; e_wreg = 0;
    endtask

    task automatic model_load(input logic [31:0] r);
        e_valid = 1'b1; e_wb = wb_ctl_i; e_m = m_ctl_i;
        e_npc = npc_i + imm_i; e_res = r; e_zero = (r == 0);
        e_rd2 = rdata2_i; e_wreg = regdst_i ? rd_i : rt_i;
        m_loaded = 1'b1;
    endtask

    // Called right after each rising edge with the pre-edge inputs still applied.
    task automatic model_edge();
        logic [31:0] r;
        logic        mul;
        m_loaded = 0; m_flushed = 0;
        if (!rst_n) return;
        ref_op(r, mul);
        if (flush_i) begin
            e_valid = 0; m_mode = 0; m_flushed = 1;
            return;
        end
        case (m_mode)
            0: if (in_valid_i && !mem_stall_i) begin
                   if (mul) begin m_prod = r; m_left = 32; m_mode = 1; e_valid = 0; end
                   else model_load(r);
               end else if (!in_valid_i && !mem_stall_i) e_valid = 0;
            1: if (m_left == 1) begin
                   if (!mem_stall_i) begin model_load(m_prod); m_mode = 0; end
                   else m_mode = 2;
               end else m_left--;
            default: if (!mem_stall_i) begin model_load(m_prod); m_mode = 0; end
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid_o, 0);
            chk("rst_alu_result", alu_result_o, 0);
            chk("rst_ex_busy", ex_busy_o, 0);
        end else begin
            chk("out_valid", out_valid_o, e_valid);
            chk("ex_busy", ex_busy_o, model_busy());
            if (e_valid) begin
                chk("alu_result", alu_result_o, e_res);
                chk("zero", zero_o, e_zero);
                chk("ex_mem_npc", ex_mem_npc_o, e_npc);
                chk("rdata2out", rdata2out_o, e_rd2);
                chk("wreg", wreg_o, e_wreg);
                chk("ctl", {wb_ctlout_o, branch_o, memread_o, memwrite_o}, {e_wb, e_m});
            end
        end
    end

    int  st_from = -1, st_len = 0, fl_at = -1;
    bit  rnd_mode = 0;

    task automatic run_instr(input logic [1:0] aluop, input logic [5:0] funct,
                             input logic alusrc, input logic regdst,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] imm, input logic [31:0] npc,
                             output int ncyc, output int nbusy);
        logic b;
        bit   fin;
        in_valid_i = 1; aluop_i = aluop; funct_i = funct; alusrc_i = alusrc;
        regdst_i = regdst; rdata1_i = r1; rdata2_i = r2; imm_i = imm; npc_i = npc;
        wb_ctl_i = 2'($urandom); m_ctl_i = 3'($urandom);
        rt_i = 5'($urandom); rd_i = 5'($urandom);
        ncyc = 0; nbusy = 0; fin = 0;
        while (!fin) begin
            if (rnd_mode) begin
                mem_stall_i = ($urandom_range(0, 99) < 15);
                flush_i     = ($urandom_range(0, 99) < 3);
            end else begin
                mem_stall_i = (ncyc >= st_from) && (ncyc < st_from + st_len);
                flush_i     = (ncyc == fl_at);
            end
            @(negedge clk);
            nbusy += int'(ex_busy_o);
            b = model_busy();
            @(posedge clk);
            model_edge();
            #1;
            ncyc++;
            fin = !b || m_loaded || m_flushed;
            if (ncyc > 500) begin
                chk("instr_timeout", ncyc, 0);
                fin = 1;
            end
        end
        in_valid_i = 0; mem_stall_i = 0; flush_i = 0;
    endtask

    task automatic idle(input int n);
        in_valid_i = 0;
        for (int i = 0; i < n; i++) begin
            mem_stall_i = rnd_mode && ($urandom_range(0, 99) < 20);
            flush_i     = rnd_mode && ($urandom_range(0, 99) < 3);
            @(posedge clk);
            model_edge();
            #1;
        end
        mem_stall_i = 0; flush_i = 0;
    endtask

    int nc, nb;
    logic [5:0] fl [0:8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h18, 6'h00, 6'h3f};

    initial begin
        rst_n = 0; in_valid_i = 0; flush_i = 0; mem_stall_i = 0;
        wb_ctl_i = 0; m_ctl_i = 0; regdst_i = 0; alusrc_i = 0; aluop_i = 0;
        npc_i = 0; rdata1_i = 0; rdata2_i = 0; imm_i = 0; rt_i = 0; rd_i = 0; funct_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("reset_out_valid", out_valid_o, 0);

        run_instr(2'b10, 6'h22, 0, 1, 32'd5, 32'd5, 32'd0, 32'd0, nc, nb);
        chk("sub_result", alu_result_o, 32'd0);
        chk("sub_zero", zero_o, 1);
        chk("sub_latency", nc, 1);
        run_instr(2'b10, 6'h2a, 0, 1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, nc, nb);
        chk("slt_result", alu_result_o, 32'd1);
        run_instr(2'b00, 6'h00, 1, 0, 32'h10, 32'd0, 32'hFFFFFFFC, 32'h100, nc, nb);
        chk("addi_result", alu_result_o, 32'hC);
        chk("br_target", ex_mem_npc_o, 32'hFC);
        chk("wreg_rt", wreg_o, rt_i);

        run_instr(2'b10, 6'h18, 0, 1, 32'd7, 32'd6, 32'd0, 32'd0, nc, nb);
        chk("mul_result", alu_result_o, 32'd42);
        chk("mul_valid", out_valid_o, 1);
        chk("mul_busy_cycles", nb, 32);
        chk("mul_occupancy", nc, 33);
        run_instr(2'b10, 6'h18, 0, 1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, nc, nb);
        chk("mul_wrap", alu_result_o, 32'hFFFFFFFE);

        // Asynchronous reset in the middle of a multiply.
        in_valid_i = 1; aluop_i = 2'b10; funct_i = 6'h18; rdata1_i = 9; rdata2_i = 9; alusrc_i = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); model_edge(); #1; end
        #2 rst_n = 0; in_valid_i = 0; model_reset();
        #1;
        chk("midmul_rst_valid", out_valid_o, 0);
        chk("midmul_rst_result", alu_result_o, 0);
        chk("midmul_rst_busy", ex_busy_o, 0);
        chk("midmul_rst_npc", ex_mem_npc_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1 chk("post_rst_busy", ex_busy_o, 0);
        idle(2);

        // Stall across the final multiply step.
        st_from = 32; st_len = 3;
        run_instr(2'b10, 6'h18, 0, 1, 32'd3, 32'd5, 32'd0, 32'd0, nc, nb);
        chk("stall_mul_cycles", nc, 36);
        chk("stall_mul_result", alu_result_o, 32'd15);
        st_from = -1; st_len = 0;

        // Flush with stall at cnt=10.
        st_from = 11; st_len = 1; fl_at = 11;
        run_instr(2'b10, 6'h18, 0, 1, 32'd11, 32'd13, 32'd0, 32'd0, nc, nb);
        chk("flush_cycles", nc, 12);
        chk("flush_valid", out_valid_o, 0);
        @(negedge clk) chk("flush_busy", ex_busy_o, 0);
        st_from = -1; st_len = 0; fl_at = -1;
        @(posedge clk); model_edge(); #1;
        idle(40);
        chk("flush_no_product", out_valid_o, 0);

        rnd_mode = 1;
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a, b;
            logic [1:0]  op;
            logic [5:0]  f;
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            op = 2'($urandom);
            f  = fl[$urandom_range(0, 8)];
            if ($urandom_range(0, 4) == 0) begin op = 2'b10; f = 6'h18; end
            run_instr(op, f, 1'($urandom), 1'($urandom), a, b, $urandom, $urandom, nc, nb);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_mode = 0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
